// File: rtl/cpu_io_pkg.sv
// Shared definitions for the peripheral I/O unit: decoded opcodes,
// output handshake states and the layout of the status word.
package cpu_io_pkg;

    localparam logic [4:0] OP_IN  = 5'b11000;
    localparam logic [4:0] OP_OUT = 5'b11001;

    typedef enum logic {
        O_IDLE = 1'b0,
        O_SEND = 1'b1
    } out_state_e;

    localparam int ST_FGI     = 0;
    localparam int ST_FGO     = 1;
    localparam int ST_DONE    = 2;
    localparam int ST_OVERRUN = 3;

endpackage

// File: rtl/io_out_fsm.sv
// Output-device handshake: holds OUTR and presents it with valid/ready
// until the device accepts it or the controller aborts with rFO.
module io_out_fsm
    import cpu_io_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       out_cmd,
    input  logic       set_fo,
    input  logic       clr_fo,
    input  logic [7:0] wr_byte,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       fgo,
    output logic       out_done,
    output logic       out_overrun
);

    out_state_e state_q, state_d;
    logic [7:0] outr_q, outr_d;
    logic       done_q, done_d;
    logic       overrun_q, overrun_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= O_IDLE;
            outr_q    <= 8'h00;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            outr_q    <= outr_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        outr_d    = outr_q;
        done_d    = done_q;
        overrun_d = overrun_q;

        // FGO is exactly "a byte is pending", so a write then is an overrun.
        if (out_cmd) begin
            if (state_q == O_SEND) begin
                overrun_d = 1'b1;
            end else begin
                outr_d = wr_byte;
            end
        end

        case (state_q)
            O_IDLE: begin
                if (set_fo) begin
                    state_d = O_SEND;
                    done_d  = 1'b0;
                end
            end
            O_SEND: begin
                if (out_ready) begin
                    state_d = O_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = O_IDLE;
        endcase

        // Abort overrides a same-cycle device acceptance.
        if (clr_fo) begin
            state_d   = O_IDLE;
            done_d    = 1'b0;
            overrun_d = 1'b0;
        end
    end

    assign out_valid   = (state_q == O_SEND);
    assign out_data    = outr_q;
    assign fgo         = (state_q == O_SEND);
    assign out_done    = done_q;
    assign out_overrun = overrun_q;

endmodule

// File: rtl/io_port_unit.sv
// Peripheral I/O and interrupt unit: input register/flag, interrupt enable,
// registered interrupt request and decode of the controller's I/O commands.
module io_port_unit
    import cpu_io_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          exec,
    input  logic [4:0]    opcode,
    input  logic          rFI,
    input  logic          sFO,
    input  logic          rFO,
    input  logic          ION,
    input  logic          IOF,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [7:0]    out_data,
    input  logic          out_ready,
    output logic          irq,
    input  logic          irq_ack,
    output logic [3:0]    status
);

    logic [7:0] inpr_q, inpr_d;
    logic       fgi_q, fgi_d;
    logic       ien_q, ien_d;
    logic       irq_q, irq_d;

    logic cmd_out, cmd_rfi, cmd_sfo, cmd_rfo, cmd_ion, cmd_iof;
    logic capture;
    logic fgo, out_done, out_overrun;
    logic unused_wr_high;

    assign cmd_out = exec && (opcode == OP_OUT);
    assign cmd_rfi = exec && rFI;
    assign cmd_sfo = exec && sFO;
    assign cmd_rfo = exec && rFO;
    assign cmd_ion = exec && ION;
    assign cmd_iof = exec && IOF;

    assign capture = in_valid && !fgi_q;

    io_out_fsm u_out_fsm (
        .clk         (clk),
        .reset       (reset),
        .out_cmd     (cmd_out),
        .set_fo      (cmd_sfo),
        .clr_fo      (cmd_rfo),
        .wr_byte     (wr_data[7:0]),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .fgo         (fgo),
        .out_done    (out_done),
        .out_overrun (out_overrun)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inpr_q <= 8'h00;
            fgi_q  <= 1'b0;
            ien_q  <= 1'b1;
            irq_q  <= 1'b0;
        end else begin
            inpr_q <= inpr_d;
            fgi_q  <= fgi_d;
            ien_q  <= ien_d;
            irq_q  <= irq_d;
        end
    end

    always_comb begin
        inpr_d = inpr_q;
        fgi_d  = fgi_q;
        ien_d  = ien_q;

        // Capture only happens with FGI clear, so it can safely win over rFI.
        if (capture) begin
            inpr_d = in_data;
            fgi_d  = 1'b1;
        end else if (cmd_rfi) begin
            fgi_d = 1'b0;
        end

        if (irq_ack || cmd_iof) begin
            ien_d = 1'b0;
        end else if (cmd_ion) begin
            ien_d = 1'b1;
        end

        irq_d = ien_q && (fgi_q || out_done);
    end

    assign rd_data  = {{(DW-8){1'b0}}, inpr_q};
    assign in_ready = !fgi_q;
    assign irq      = irq_q;

    assign status[ST_FGI]     = fgi_q;
    assign status[ST_FGO]     = fgo;
    assign status[ST_DONE]    = out_done;
    assign status[ST_OVERRUN] = out_overrun;

    assign unused_wr_high = ^wr_data[DW-1:8];

endmodule

// File: tb/tb_io_port_unit.sv
// Directed self-checking bench for io_port_unit: input capture, output
// handshake with stall/overrun/abort, interrupt enable and async reset.
module tb_io_port_unit;

    localparam int DW = 16;

    logic          clk;
    logic          reset;
    logic          exec;
    logic [4:0]    opcode;
    logic          rFI, sFO, rFO, ION, IOF;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_ready;
    logic          irq;
    logic          irq_ack;
    logic [3:0]    status;

    int checkCount = 0;
    int errCount   = 0;

    io_port_unit #(.DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .exec      (exec),
        .opcode    (opcode),
        .rFI       (rFI),
        .sFO       (sFO),
        .rFO       (rFO),
        .ION       (ION),
        .IOF       (IOF),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .irq       (irq),
        .irq_ack   (irq_ack),
        .status    (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            errCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] op, input logic [DW-1:0] wd,
                                 input logic r_fi, input logic s_fo, input logic r_fo,
                                 input logic i_on, input logic i_of);
        exec    = 1'b1;
        opcode  = op;
        wr_data = wd;
        rFI     = r_fi;
        sFO     = s_fo;
        rFO     = r_fo;
        ION     = i_on;
        IOF     = i_of;
        step();
        exec   = 1'b0;
        opcode = 5'b00000;
        rFI    = 1'b0;
        sFO    = 1'b0;
        rFO    = 1'b0;
        ION    = 1'b0;
        IOF    = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        exec      = 1'b0;
        opcode    = 5'b00000;
        rFI       = 1'b0;
        sFO       = 1'b0;
        rFO       = 1'b0;
        ION       = 1'b0;
        IOF       = 1'b0;
        wr_data   = '0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        irq_ack   = 1'b0;

        step();
        step();
        reset = 1'b0;
        checkOutput("reset_rd_data", 32'(rd_data), 32'h0000);
        checkOutput("reset_in_ready", 32'(in_ready), 32'h1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
        checkOutput("reset_irq", 32'(irq), 32'h0);
        checkOutput("reset_status", 32'(status), 32'h0);

        // Input capture
        in_valid = 1'b1;
        in_data  = 8'h41;
        step();
        checkOutput("cap_status", 32'(status), 32'h1);
        checkOutput("cap_in_ready", 32'(in_ready), 32'h0);
        checkOutput("cap_rd_data", 32'(rd_data), 32'h0041);
        checkOutput("cap_irq_early", 32'(irq), 32'h0);
        step();
        in_valid = 1'b0;
        checkOutput("cap_irq", 32'(irq), 32'h1);

        // rFI without exec is ignored
        rFI = 1'b1;
        step();
        rFI = 1'b0;
        checkOutput("noexec_rfi_status", 32'(status), 32'h1);

        applyStimulus(5'b00000, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rfi_status", 32'(status), 32'h0);
        checkOutput("rfi_in_ready", 32'(in_ready), 32'h1);
        step();
        checkOutput("rfi_irq_clear", 32'(irq), 32'h0);

        // OUT then sFO with a stalled device
        applyStimulus(5'b11001, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("out_load_valid", 32'(out_valid), 32'h0);
        checkOutput("out_load_status", 32'(status), 32'h0);
        applyStimulus(5'b00000, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("sfo_valid", 32'(out_valid), 32'h1);
        checkOutput("sfo_data", 32'(out_data), 32'h34);
        checkOutput("sfo_status", 32'(status), 32'h2);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("stall_valid_%0d", i), 32'(out_valid), 32'h1);
            checkOutput($sformatf("stall_data_%0d", i), 32'(out_data), 32'h34);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checkOutput("accept_valid", 32'(out_valid), 32'h0);
        checkOutput("accept_status", 32'(status), 32'h4);
        step();
        checkOutput("accept_irq", 32'(irq), 32'h1);

        // Overrun while a byte is pending, then abort
        applyStimulus(5'b00000, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("resend_status", 32'(status), 32'h2);
        applyStimulus(5'b11001, 16'h0055, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("overrun_data", 32'(out_data), 32'h34);
        checkOutput("overrun_status", 32'(status), 32'hA);
        applyStimulus(5'b00000, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("abort_valid", 32'(out_valid), 32'h0);
        checkOutput("abort_status", 32'(status), 32'h0);

        // rFO races device acceptance; abort wins
        applyStimulus(5'b00000, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("race_send_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        applyStimulus(5'b00000, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        out_ready = 1'b0;
        checkOutput("race_valid", 32'(out_valid), 32'h0);
        checkOutput("race_status", 32'(status), 32'h0);
        step();
        step();
        checkOutput("race_irq", 32'(irq), 32'h0);

        // Interrupt enable control
        applyStimulus(5'b00000, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h7A;
        step();
        in_valid = 1'b0;
        checkOutput("iof_status", 32'(status), 32'h1);
        checkOutput("iof_rd_data", 32'(rd_data), 32'h007A);
        step();
        step();
        checkOutput("iof_irq", 32'(irq), 32'h0);
        applyStimulus(5'b00000, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        checkOutput("ion_irq", 32'(irq), 32'h1);
        irq_ack = 1'b1;
        applyStimulus(5'b00000, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        irq_ack = 1'b0;
        step();
        checkOutput("ack_irq", 32'(irq), 32'h0);
        step();
        checkOutput("ack_irq_hold", 32'(irq), 32'h0);

        // Asynchronous reset in the middle of a send
        applyStimulus(5'b00000, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(5'b00000, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_reset_valid", 32'(out_valid), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_valid", 32'(out_valid), 32'h0);
        checkOutput("async_status", 32'(status), 32'h0);
        checkOutput("async_rd_data", 32'(rd_data), 32'h0000);
        checkOutput("async_in_ready", 32'(in_ready), 32'h1);
        checkOutput("async_irq", 32'(irq), 32'h0);
        step();
        reset = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h0C;
        step();
        in_valid = 1'b0;
        step();
        checkOutput("post_reset_ien_irq", 32'(irq), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, errCount);
        $finish;
    end

endmodule
